// File: rtl/axi_lite_delayed_sram_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_delayed_sram_pkg
//   Shared definitions for the trigger-delayed AXI4-Lite SRAM model:
//   AXI response codes and the read/write channel FSM state encodings.
// ---------------------------------------------------------------------------
package axi_lite_delayed_sram_pkg;

  // AXI4-Lite response codes used by this slave.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read channel: idle -> waiting for trigger -> holding response.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  // Write channel: collecting AW/W -> waiting for trigger -> holding response.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_lite_sram_array.sv
// ---------------------------------------------------------------------------
// axi_lite_sram_array
//   DEPTH x 32-bit word storage with one byte-strobed synchronous write port
//   and one asynchronous read port.
//
//   Ports:
//     clk      in   clock (write on posedge)
//     we_i     in   write enable
//     waddr_i  in   write word index
//     wdata_i  in   write data
//     wstrb_i  in   byte enables for the write
//     raddr_i  in   read word index
//     rdata_o  out  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module axi_lite_sram_array #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: storage has no reset branch; a memory array with reset cannot map
  // onto RAM macros and would need DEPTH*32 resettable flops.
  // NOTE: non-blocking writes mean a read sampled on the same edge as a write
  // observes the old word, which gives read-before-write ordering for free.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_delayed_sram.sv
// ---------------------------------------------------------------------------
// axi_lite_delayed_sram
//   AXI4-Lite slave SRAM whose responses are released by an external
//   delay_trigger pulse. Read and write channels run independent FSMs and
//   share one word-organised storage array. An accepted request waits until
//   the first cycle the trigger is high; triggers seen while a channel is idle
//   or holding a response are dropped.
//
//   Ports:
//     clk, rst              clock / async active-low reset
//     delay_trigger         latency release pulse
//     araddr/arvalid/arready            read address channel
//     rdata/rresp/rvalid/rready         read data channel
//     awaddr/awvalid/awready            write address channel
//     wdata/wstrb/wvalid/wready         write data channel
//     bresp/bvalid/bready               write response channel
// ---------------------------------------------------------------------------
module axi_lite_delayed_sram
  import axi_lite_delayed_sram_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              delay_trigger,
  // read address / data
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  // write address / data / response
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rd_state_e         r_state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  wr_state_e         w_state_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  // ---------------------------------------------------------------------------
  // Address decode on the latched addresses. The subtraction wraps for
  // addresses below BASE, so the explicit lower-bound compare is required.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  assign rd_off      = araddr_q - BASE;
  assign wr_off      = awaddr_q - BASE;
  assign rd_in_range = (araddr_q >= BASE) && ((rd_off >> 2) < DEPTH_A);
  assign wr_in_range = (awaddr_q >= BASE) && ((wr_off >> 2) < DEPTH_A);
  assign rd_idx      = rd_off[IDX_W+1:2];
  assign wr_idx      = wr_off[IDX_W+1:2];

  // ---------------------------------------------------------------------------
  // Storage. The commit happens on the trigger edge in W_WAIT; the read FSM
  // samples the async port on that same edge and therefore sees pre-write data.
  // ---------------------------------------------------------------------------
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign mem_we = (w_state_q == W_WAIT) && delay_trigger && wr_in_range;

  axi_lite_sram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_idx),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .raddr_i (rd_idx),
    .rdata_o (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            araddr_q  <= araddr;
            arready_q <= 1'b0;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (delay_trigger) begin
            rdata_q   <= rd_in_range ? mem_rdata : 32'h0;
            rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q  <= 1'b1;
            r_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          // arready returns the cycle after the R handshake, never the same one.
          if (rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM. AW and W are captured independently in W_IDLE; each ready
  // drops once its half is held, and the FSM leaves W_IDLE when both are held
  // (including the case where both handshake on the same edge).
  // ---------------------------------------------------------------------------
  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q  <= awaddr;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= wdata;
            wstrb_q  <= wstrb;
            wready_q <= 1'b0;
          end
          if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
            w_state_q <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (delay_trigger) begin
            bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are driven straight from registers.
  // ---------------------------------------------------------------------------
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_delayed_sram.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_delayed_sram
//   Self-checking bench: a transaction-level model tracks each channel's
//   phase and a sparse word memory; a compare process checks every DUT output
//   on each falling edge, directed scenarios pin literal values, and a
//   randomized phase exercises concurrent traffic and trigger timing.
// ---------------------------------------------------------------------------
module tb_axi_lite_delayed_sram;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        delay_trigger = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  always #5 clk = ~clk;

  axi_lite_delayed_sram #(
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .BASE   (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .delay_trigger (delay_trigger),
    .araddr        (araddr),
    .arvalid       (arvalid),
    .arready       (arready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rvalid        (rvalid),
    .rready        (rready),
    .awaddr        (awaddr),
    .awvalid       (awvalid),
    .awready       (awready),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .wvalid        (wvalid),
    .wready        (wready),
    .bresp         (bresp),
    .bvalid        (bvalid),
    .bready        (bready)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: channel phase 0 = idle, 1 = waiting for trigger,
  // 2 = response presented. Memory is sparse; absent words are unknown.
  // ---------------------------------------------------------------------------
  int          r_ph, w_ph;
  bit          have_aw, have_w;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp, exp_bresp;
  bit          exp_rknown;
  logic [31:0] mem_m [int];

  function automatic bit m_in_range(input logic [31:0] a);
    longint d;
    d = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (d >= 0) && (d / 4 < DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    longint d;
    d = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return int'(d / 4);
  endfunction

  task automatic model_reset();
    r_ph = 0; w_ph = 0; have_aw = 0; have_w = 0;
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    exp_rdata = '0; exp_rresp = 2'b00; exp_bresp = 2'b00; exp_rknown = 1;
  endtask

  task automatic model_step();
    int          i;
    logic [31:0] merged;
    // Read side first: it observes memory before any same-edge write.
    case (r_ph)
      0: if (arvalid) begin m_araddr = araddr; r_ph = 1; end
      1: if (delay_trigger) begin
        if (m_in_range(m_araddr)) begin
          i = m_idx(m_araddr);
          exp_rresp  = 2'b00;
          exp_rknown = mem_m.exists(i);
          exp_rdata  = exp_rknown ? mem_m[i] : 32'h0;
        end else begin
          exp_rresp = 2'b10; exp_rdata = 32'h0; exp_rknown = 1;
        end
        r_ph = 2;
      end
      default: if (rready) r_ph = 0;
    endcase
    case (w_ph)
      0: begin
        if (awvalid && !have_aw) begin m_awaddr = awaddr; have_aw = 1; end
        if (wvalid && !have_w) begin m_wdata = wdata; m_wstrb = wstrb; have_w = 1; end
        if (have_aw && have_w) w_ph = 1;
      end
      1: if (delay_trigger) begin
        if (m_in_range(m_awaddr)) begin
          i = m_idx(m_awaddr);
          exp_bresp = 2'b00;
          if (mem_m.exists(i) || m_wstrb == 4'hF) begin
            merged = mem_m.exists(i) ? mem_m[i] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) merged[8*b +: 8] = m_wdata[8*b +: 8];
            mem_m[i] = merged;
          end
        end else begin
          exp_bresp = 2'b10;
        end
        w_ph = 2;
      end
      default: if (bready) begin w_ph = 0; have_aw = 0; have_w = 0; end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Compare process: every output, every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("arready", arready, r_ph == 0);
      check("rvalid",  rvalid,  r_ph == 2);
      check("rresp",   rresp,   exp_rresp);
      if (exp_rknown) check("rdata", rdata, exp_rdata);
      check("awready", awready, (w_ph == 0) && !have_aw);
      check("wready",  wready,  (w_ph == 0) && !have_w);
      check("bvalid",  bvalid,  w_ph == 2);
      check("bresp",   bresp,   exp_bresp);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse();
    delay_trigger = 1'b1; tick(); delay_trigger = 1'b0;
  endtask

  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 100) begin tick(); n++; end
    check("write_accept_bound", n < 100, 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic finish_write(output logic [1:0] r);
    int n = 0;
    while (!bvalid && n < 100) begin tick(); n++; end
    check("bvalid_bound", n < 100, 1);
    r = bresp;
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic start_read(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 100) begin tick(); n++; end
    check("read_accept_bound", n < 100, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic finish_read(output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    while (!rvalid && n < 100) begin tick(); n++; end
    check("rvalid_bound", n < 100, 1);
    d = rdata; r = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    start_write(a, d, s); pulse(); finish_write(r);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    start_read(a); pulse(); finish_read(d, r);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12) return BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
    case (r)
      12:      return BASE + 32'(4 * (DEPTH - 1));
      13:      return BASE + 32'(4 * DEPTH);
      14:      return BASE - 32'd4;
      default: return 32'hFFFF_FFF0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [31:0] rd_d;
  logic [1:0]  rd_r, wr_r;
  bit          ar_hs, aw_hs, w_hs;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_wready",  wready,  1);
    check("rst_rvalid",  rvalid,  0);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rdata",   rdata,   32'h0);
    rst = 1'b1;
    tick();

    // Write DEADBEEF, trigger 5 cycles after the handshake
    start_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    repeat (4) tick();
    check("t1_bvalid_before", bvalid, 0);
    pulse();
    check("t1_bvalid_after", bvalid, 1);
    check("t1_bresp", bresp, 2'b00);
    finish_write(wr_r);
    do_read(32'h8000_0010, rd_d, rd_r);
    check("t1_rdata", rd_d, 32'hDEAD_BEEF);
    check("t1_rresp", rd_r, 2'b00);

    // W arrives 3 cycles before AW, byte-lane merge
    do_write(32'h8000_0014, 32'h1122_3344, 4'hF, wr_r);
    wdata = 32'h0000_AB00; wstrb = 4'b0010; wvalid = 1'b1;
    tick(); wvalid = 1'b0;
    check("t2_wready_low", wready, 0);
    check("t2_awready_high", awready, 1);
    tick(); tick();
    awaddr = 32'h8000_0014; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    pulse();
    finish_write(wr_r);
    check("t2_bresp", wr_r, 2'b00);
    do_read(32'h8000_0014, rd_d, rd_r);
    check("t2_rdata", rd_d, 32'h1122_AB44);

    // Out-of-range accesses
    do_write(BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D, 4'hF, wr_r);
    do_read(32'h7FFF_FFFC, rd_d, rd_r);
    check("t3_low_rresp", rd_r, 2'b10);
    check("t3_low_rdata", rd_d, 32'h0);
    do_read(BASE + 32'(4 * DEPTH), rd_d, rd_r);
    check("t3_high_rresp", rd_r, 2'b10);
    check("t3_high_rdata", rd_d, 32'h0);
    do_write(BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF, wr_r);
    check("t3_bresp", wr_r, 2'b10);
    do_read(BASE + 32'(4 * (DEPTH - 1)), rd_d, rd_r);
    check("t3_last_word", rd_d, 32'hCAFE_F00D);

    // rready held low for 10 cycles
    start_read(32'h8000_0010);
    pulse();
    for (int k = 0; k < 10; k++) begin
      check("t4_rvalid_hold", rvalid, 1);
      check("t4_rdata_hold", rdata, 32'hDEAD_BEEF);
      check("t4_arready_low", arready, 0);
      tick();
    end
    rready = 1'b1;
    check("t4_arready_pre_hs", arready, 0);
    tick();
    rready = 1'b0;
    check("t4_arready_post_hs", arready, 1);
    check("t4_rvalid_post_hs", rvalid, 0);

    // Same-index read and write released by one trigger
    do_write(32'h8000_0008, 32'h0000_0001, 4'hF, wr_r);
    araddr = 32'h8000_0008; arvalid = 1'b1;
    awaddr = 32'h8000_0008; wdata = 32'h0000_0002; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    pulse();
    check("t5_rvalid", rvalid, 1);
    check("t5_bvalid", bvalid, 1);
    check("t5_rdata_old", rdata, 32'h0000_0001);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0008, rd_d, rd_r);
    check("t5_rdata_new", rd_d, 32'h0000_0002);

    // Reset while a write waits for its trigger
    do_write(32'h8000_000C, 32'h0000_0033, 4'hF, wr_r);
    start_write(32'h8000_000C, 32'h0000_0099, 4'hF);
    tick();
    rst = 1'b0;
    #1;
    check("t6_bvalid", bvalid, 0);
    check("t6_awready", awready, 1);
    check("t6_wready", wready, 1);
    check("t6_arready", arready, 1);
    check("t6_rdata", rdata, 32'h0);
    check("t6_bresp", bresp, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    pulse();
    tick();
    check("t6_no_bvalid", bvalid, 0);
    do_read(32'h8000_000C, rd_d, rd_r);
    check("t6_unchanged", rd_d, 32'h0000_0033);

    // Randomized concurrent traffic
    for (int c = 0; c < 3000; c++) begin
      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (ar_hs) arvalid = 1'b0;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        araddr = rand_addr(); arvalid = 1'b1;
      end
      if (!awvalid && $urandom_range(0, 2) == 0) begin
        awaddr = rand_addr(); awvalid = 1'b1;
      end
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wdata = $urandom;
        wstrb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        wvalid = 1'b1;
      end
      delay_trigger = ($urandom_range(0, 3) == 0);
      rready        = ($urandom_range(0, 1) == 1);
      bready        = ($urandom_range(0, 1) == 1);
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    delay_trigger = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_lite_delayed_sram.md
Name: axi_lite_delayed_sram

Overview:
- AXI4-Lite slave SRAM model for the NPC simulation environment. It sits directly downstream of the random delay generator and consumes its `delay_trigger` pulse.
- Every accepted read or write is held until a trigger pulse arrives. This gives the IFU/LSU masters a realistic, variable memory latency.
- Read and write channels are independent. Each channel has its own FSM and shares one word-organised storage array.

Parameters:
- ADDR_W, 32, AXI address width.
- DEPTH, 4096, number of 32-bit words in storage.
- BASE, 32'h8000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous active-low reset; rst==0 resets immediately, independent of clk.
- delay_trigger  in  1  latency release pulse from the delay generator.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset values (async, active-low):
  - Read FSM = R_IDLE, write FSM = W_IDLE.
  - arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Latched address/data/strobe registers = 0.
  - Storage contents are not reset.
- Address decode:
  - idx = (addr - BASE) >> 2; addr[1:0] is ignored.
  - In range when addr >= BASE and idx < DEPTH; otherwise the access is an error.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&arready, latch araddr → R_WAIT.
  - R_WAIT: arready=0. In the first cycle delay_trigger==1, sample storage (or 0 with SLVERR if out of range) into rdata/rresp, set rvalid=1 → R_RESP.
  - R_RESP: hold rdata/rresp stable. On rvalid&rready: rvalid=0 → R_IDLE; next AR is accepted no earlier than the following cycle.
- Write FSM:
  - W_IDLE: awready=wready=1. AW and W may arrive in either order or together; each is latched on its own handshake and its ready drops once captured. When both are held → W_WAIT. If both handshake in the same cycle, go directly to W_WAIT.
  - W_WAIT: first cycle with delay_trigger==1:
    - In range: commit wdata to storage per set wstrb bits; bresp=OKAY.
    - Out of range: no storage change; bresp=SLVERR.
    - Set bvalid=1 → W_RESP.
  - W_RESP: on bvalid&bready: bvalid=0 → W_IDLE.
- Trigger rules:
  - Minimum latency from handshake to valid is 1 cycle: a trigger already high in the cycle after capture releases immediately.
  - A trigger seen while a channel is in IDLE or RESP is ignored; triggers are not queued.
  - One trigger pulse may release both channels in the same cycle.
- Same-cycle read and write to the same index: the read returns pre-write data.
- Masters may hold rready/bready high early; valid never depends combinationally on ready.
- rst asserted mid-transaction: the transaction is discarded, no response is issued, and any uncommitted write is lost.

Decomposition:
- Shared package:
  - AXI response constants OKAY=2'b00, SLVERR=2'b10.
  - Read-FSM and write-FSM state encodings.
- One natural sub-module: axi_lite_sram_array. Single write port with byte strobes, single async read port, DEPTH x 32. It is instantiated once and driven by both FSMs.

Test Plan:
- Write 0x8000_0010 data 0xDEADBEEF strb 4'hF, trigger pulsed 5 cycles after handshake -> bvalid exactly 1 cycle after the pulse, bresp=00; then read same address -> rdata=0xDEADBEEF, rresp=00.
- W before AW by 3 cycles, wstrb=4'b0010, wdata=0x0000AB00 over stored 0x11223344 -> after release, read returns 0x1122AB44.
- Read 0x7FFF_FFFC and read BASE+4*DEPTH -> both rresp=10, rdata=0; write to BASE+4*DEPTH -> bresp=10 and word DEPTH-1 is unchanged.
- rready held low 10 cycles after rvalid -> rvalid and rdata stay constant; arready stays 0 until the cycle after the rready handshake.
- Read and write to the same index pending, both released by one trigger, old value 0x1, new value 0x2 -> rdata=0x1; a later read returns 0x2.
- rst pulled low while in W_WAIT, released, then trigger -> no bvalid, storage unchanged, all outputs at reset values.
